// File: rtl/invader_fleet_ctrl.sv
// -----------------------------------------------------------------------------
// invader_fleet_ctrl
//
// Sequences the invader formation. It owns the alive bitmap and marches the
// formation one step every `period` frames. At a screen edge it drops the
// formation and reverses its direction. The march speeds up as invaders die
// (period = max(PERIOD_MIN, alive_count)). It accepts kill requests from the
// collision logic. It raises sticky cleared/landed flags for game-state logic.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   frame           one-cycle pulse per video frame (drives step scheduling)
//   start           begins a wave from IDLE, reloads a wave from CLEARED
//   enable          pause when low (frame counter and motion hold)
//   kill_valid      kill request strobe, with kill_row / kill_col address
//   fleet_x/_y      formation origin (top-left of cell row 0, col 0)
//   dir_right       1 = marching right
//   alive           alive bitmap, bit index = row*COLS + col
//   alive_count     population count of alive
//   step_pulse      one cycle per executed step or drop
//   fleet_cleared   sticky, every invader killed
//   fleet_landed    sticky, formation bottom reached LAND_Y
// All outputs are registered.
// -----------------------------------------------------------------------------
module invader_fleet_ctrl #(
  parameter int ROWS       = 4,
  parameter int COLS       = 8,
  parameter int CELL_W     = 32,
  parameter int CELL_H     = 24,
  parameter int START_X    = 64,
  parameter int START_Y    = 48,
  parameter int X_MIN      = 16,
  parameter int X_MAX      = 624,
  parameter int STEP_X     = 4,
  parameter int STEP_Y     = 16,
  parameter int LAND_Y     = 400,
  parameter int PERIOD_MIN = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             frame,
  input  logic                             start,
  input  logic                             enable,
  input  logic                             kill_valid,
  input  logic [$clog2(ROWS)-1:0]          kill_row,
  input  logic [$clog2(COLS)-1:0]          kill_col,
  output logic [9:0]                       fleet_x,
  output logic [9:0]                       fleet_y,
  output logic                             dir_right,
  output logic [ROWS*COLS-1:0]             alive,
  output logic [$clog2(ROWS*COLS+1)-1:0]   alive_count,
  output logic                             step_pulse,
  output logic                             fleet_cleared,
  output logic                             fleet_landed
);

  localparam int N   = ROWS * COLS;
  localparam int ACW = $clog2(N + 1);
  localparam int IW  = $clog2(N);
  localparam int CW  = $clog2(COLS);
  localparam int RW  = $clog2(ROWS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MARCH   = 2'd1,
    ST_CLEARED = 2'd2,
    ST_LANDED  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [9:0]       fleet_x_q, fleet_x_d;
  logic [9:0]       fleet_y_q, fleet_y_d;
  logic             dir_q, dir_d;
  logic [N-1:0]     alive_q, alive_d;
  logic [ACW-1:0]   count_q, count_d;
  logic [ACW-1:0]   frame_cnt_q, frame_cnt_d;
  logic             step_q, step_d;
  logic             cleared_q, cleared_d;
  logic             landed_q, landed_d;

  logic [COLS-1:0]  col_any_s;
  logic [ROWS-1:0]  row_any_s;
  logic [CW-1:0]    l_col_s, r_col_s;
  logic [RW-1:0]    b_row_s;
  logic [11:0]      left_edge_s, right_edge_s, bottom_s;
  logic [9:0]       x_step_s, y_drop_s;
  logic             drop_s, land_s;
  logic [ACW-1:0]   period_s;
  logic [IW-1:0]    kill_idx_s;
  logic             kill_ok_s;

  // Occupancy per column/row, then leftmost/rightmost column and bottom row.
  always_comb begin
    col_any_s = '0;
    row_any_s = '0;
    l_col_s   = '0;
    r_col_s   = '0;
    b_row_s   = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        col_any_s[c] = col_any_s[c] | alive_q[r*COLS + c];
        row_any_s[r] = row_any_s[r] | alive_q[r*COLS + c];
      end
    end
    // Descending scan leaves the lowest occupied column in l_col_s.
    for (int c = COLS - 1; c >= 0; c--) begin
      l_col_s = col_any_s[c] ? CW'(c) : l_col_s;
    end
    for (int c = 0; c < COLS; c++) begin
      r_col_s = col_any_s[c] ? CW'(c) : r_col_s;
    end
    for (int r = 0; r < ROWS; r++) begin
      b_row_s = row_any_s[r] ? RW'(r) : b_row_s;
    end
  end

  // Edge tests, candidate move/drop results, landing test and step period.
  always_comb begin
    left_edge_s  = 12'(fleet_x_q) + 12'(l_col_s) * 12'(CELL_W);
    right_edge_s = 12'(fleet_x_q) + (12'(r_col_s) + 12'd1) * 12'(CELL_W);
    x_step_s     = dir_q ? (fleet_x_q + 10'(STEP_X)) : (fleet_x_q - 10'(STEP_X));
    y_drop_s     = fleet_y_q + 10'(STEP_Y);
    bottom_s     = 12'(y_drop_s) + (12'(b_row_s) + 12'd1) * 12'(CELL_H);
    land_s       = (bottom_s >= 12'(LAND_Y));
    // The origin is unsigned, so when the left column has been shot away a
    // further left step could take fleet_x below zero; that case drops too.
    if (dir_q) begin
      drop_s = (right_edge_s + 12'(STEP_X)) > 12'(X_MAX);
    end else begin
      drop_s = (left_edge_s < 12'(X_MIN + STEP_X)) || (fleet_x_q < 10'(STEP_X));
    end
    if (count_q > ACW'(PERIOD_MIN)) begin
      period_s = count_q;
    end else begin
      period_s = ACW'(PERIOD_MIN);
    end
  end

  // Kill request decode: in range, addressed invader alive, wave active.
  always_comb begin
    kill_idx_s = IW'(int'(kill_row) * COLS + int'(kill_col));
    kill_ok_s  = kill_valid
              && ((state_q == ST_MARCH) || (state_q == ST_CLEARED))
              && (int'(kill_row) < ROWS) && (int'(kill_col) < COLS)
              && alive_q[kill_idx_s];
  end

  // Next-state, motion scheduling and kill application.
  always_comb begin
    state_d     = state_q;
    fleet_x_d   = fleet_x_q;
    fleet_y_d   = fleet_y_q;
    dir_d       = dir_q;
    alive_d     = alive_q;
    count_d     = count_q;
    frame_cnt_d = frame_cnt_q;
    step_d      = 1'b0;
    cleared_d   = cleared_q;
    landed_d    = landed_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_MARCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MARCH: begin
        // An empty bitmap wins over motion; extents are meaningless then.
        if (alive_q == '0) begin
          state_d   = ST_CLEARED;
          cleared_d = 1'b1;
        end else if (enable && frame) begin
          if (frame_cnt_q >= period_s - ACW'(1)) begin
            frame_cnt_d = '0;
            step_d      = 1'b1;
            if (drop_s) begin
              fleet_y_d = y_drop_s;
              dir_d     = ~dir_q;
              if (land_s) begin
                state_d  = ST_LANDED;
                landed_d = 1'b1;
              end else begin
                state_d  = ST_MARCH;
              end
            end else begin
              fleet_x_d = x_step_s;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + ACW'(1);
          end
        end else begin
          frame_cnt_d = frame_cnt_q;
        end
      end
      ST_CLEARED: begin
        if (start) begin
          state_d     = ST_MARCH;
          fleet_x_d   = 10'(START_X);
          fleet_y_d   = 10'(START_Y);
          dir_d       = 1'b1;
          alive_d     = '1;
          count_d     = ACW'(N);
          frame_cnt_d = '0;
          cleared_d   = 1'b0;
        end else begin
          state_d = ST_CLEARED;
        end
      end
      ST_LANDED: begin
        state_d = ST_LANDED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A kill in the same cycle as a move is independent of it: the move has
    // already been computed from the pre-kill extents above.
    if (kill_ok_s) begin
      alive_d[kill_idx_s] = 1'b0;
      count_d             = count_q - ACW'(1);
    end else begin
      count_d = count_d;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      fleet_x_q   <= 10'(START_X);
      fleet_y_q   <= 10'(START_Y);
      dir_q       <= 1'b1;
      alive_q     <= '1;
      count_q     <= ACW'(N);
      frame_cnt_q <= '0;
      step_q      <= 1'b0;
      cleared_q   <= 1'b0;
      landed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fleet_x_q   <= fleet_x_d;
      fleet_y_q   <= fleet_y_d;
      dir_q       <= dir_d;
      alive_q     <= alive_d;
      count_q     <= count_d;
      frame_cnt_q <= frame_cnt_d;
      step_q      <= step_d;
      cleared_q   <= cleared_d;
      landed_q    <= landed_d;
    end
  end

  assign fleet_x       = fleet_x_q;
  assign fleet_y       = fleet_y_q;
  assign dir_right     = dir_q;
  assign alive         = alive_q;
  assign alive_count   = count_q;
  assign step_pulse    = step_q;
  assign fleet_cleared = cleared_q;
  assign fleet_landed  = landed_q;

endmodule

// File: doc/invader_fleet_ctrl.md
Name: invader_fleet_ctrl

Overview:
- Sequences the invader formation.
- Owns the alive bitmap, marches the formation one step every N frames, drops it and reverses direction at the screen edges, and speeds up as invaders die.
- Accepts kill requests from collision logic. Raises sticky cleared/landed flags for the score/game-state logic.
- Sits beside player/laser; its position and alive outputs feed the VGA renderer and collision checks.

Parameters:
- ROWS, 4, formation rows.
- COLS, 8, formation columns.
- CELL_W, 32, horizontal pitch of one invader cell (px).
- CELL_H, 24, vertical pitch of one invader cell (px).
- START_X, 64, formation origin x on reset/reload.
- START_Y, 48, formation origin y on reset/reload.
- X_MIN, 16, leftmost legal pixel.
- X_MAX, 624, rightmost legal extent (exclusive).
- STEP_X, 4, horizontal step (px).
- STEP_Y, 16, drop distance (px).
- LAND_Y, 400, y at which the formation has landed.
- PERIOD_MIN, 2, minimum frames per step.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- frame  in  1  one-cycle pulse per video frame
- start  in  1  one-cycle pulse; begins/reloads a wave
- enable  in  1  pause when low (counter and motion hold)
- kill_valid  in  1  kill request strobe
- kill_row  in  $clog2(ROWS)  row of invader to kill
- kill_col  in  $clog2(COLS)  column of invader to kill
- fleet_x  out  10  formation origin x
- fleet_y  out  10  formation origin y
- dir_right  out  1  1 = marching right
- alive  out  ROWS*COLS  alive bitmap, bit = row*COLS+col
- alive_count  out  $clog2(ROWS*COLS+1)  number of set bits in alive
- step_pulse  out  1  one cycle per executed step or drop
- fleet_cleared  out  1  sticky, alive == 0
- fleet_landed  out  1  sticky, bottom reached LAND_Y

Behaviour:
- Reset (rst high at posedge):
  - state=IDLE; fleet_x=START_X; fleet_y=START_Y; dir_right=1.
  - alive=all ones; alive_count=ROWS*COLS; frame_cnt=0.
  - step_pulse=0; fleet_cleared=0; fleet_landed=0.
  - rst has priority over every other input.
- FSM:
  - IDLE: start → MARCH.
  - MARCH: alive==0 → CLEARED (fleet_cleared=1). Landing condition → LANDED (fleet_landed=1).
  - CLEARED: start reloads position, dir and alive (as reset) and clears fleet_cleared → MARCH.
  - LANDED: terminal until rst.
  - No motion outside MARCH.
- Step scheduling:
  - period = max(PERIOD_MIN, alive_count).
  - In MARCH with enable=1, on each frame pulse: if frame_cnt >= period-1, execute a move and set frame_cnt=0; else frame_cnt+1.
  - enable=0 holds frame_cnt.
  - The move and step_pulse are registered one cycle after the frame pulse.
- Extents:
  - Computed from the registered alive bitmap.
  - L/R = lowest/highest column with any alive bit; B = highest row with any alive bit.
  - Left edge = fleet_x + L*CELL_W. Right edge = fleet_x + (R+1)*CELL_W.
  - Use ≥11-bit arithmetic; no underflow wrap.
- Move:
  - If dir_right and right edge + STEP_X > X_MAX → drop.
  - Else if !dir_right and left edge < X_MIN + STEP_X → drop.
  - Otherwise fleet_x ± STEP_X.
  - Drop: fleet_y += STEP_Y, dir_right toggles, fleet_x unchanged.
- Landing:
  - Evaluated after each drop: fleet_y_new + (B+1)*CELL_H >= LAND_Y → LANDED the next cycle.
  - No further moves after landing.
- Kill:
  - kill_valid with in-range row/col and the addressed bit set → bit cleared and alive_count decremented on the next edge.
  - Dead bit or out-of-range index → ignored, no change.
  - Kills are accepted in every state except IDLE/LANDED.
- Simultaneous kill and move in the same cycle: both apply; the move uses pre-kill extents.
- Last kill: the kill that zeroes alive enters CLEARED on the following cycle. Any pending move in that cycle still completes.
- start while in MARCH is ignored.

Test Plan:
- Reset, start, then frame pulses → step_pulse every 32 frames. First 76 steps: fleet_x 64→368, fleet_y=48. Step 77: fleet_y=64, fleet_x=368, dir_right=0.
- kill row0 col7 → alive[7]=0, alive_count=31 next cycle. Repeat same kill → alive and count unchanged. kill_col out of range → ignored.
- Kill all of column 7 (4 kills) → R=6. Right march continues to fleet_x=400 before the drop.
- Kill 31 invaders → period=2 (count 1, clamped). Kill the last → fleet_cleared=1, motion stops. start → alive=all ones, fleet_x=64, fleet_y=48, cleared=0.
- Run 16 drops with the full formation → fleet_y=304, bottom 400 ≥ LAND_Y → fleet_landed=1. No further step_pulse; start ignored.
- enable=0 for 10 frames mid-count → no step, frame_cnt held. Assert rst mid-march → all outputs at reset values on the next edge.
